// File: rtl/arith_pkg.sv
// ============================================================================
// arith_pkg : widths, FSM encoding and saturation limits shared by arithmetic IP
// Revision  : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package arith_pkg;

    localparam int DW = 24;
    localparam int VW = 12;
    localparam int CNT_W = 5;

    localparam logic [CNT_W-1:0] ITER_COUNT = 5'd24;
    localparam logic [VW-1:0]    Q_MAX      = 12'h7FF;
    localparam logic [VW-1:0]    Q_MIN      = 12'h800;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } div_state_t;

    // Magnitudes are unsigned, so the most negative input maps to 2^(W-1) exactly.
    function automatic logic [DW-1:0] abs_dw(input logic [DW-1:0] x);
        return x[DW-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [VW-1:0] abs_vw(input logic [VW-1:0] x);
        return x[VW-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// div_step : one radix-2 restoring step (shift in a dividend bit, trial subtract)
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module div_step
    import arith_pkg::*;
(
    input  logic [VW:0]   rem_in,
    input  logic          dvd_bit,
    input  logic [VW-1:0] dvs,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {2'b00, dvs};
        q_bit   = ~diff[VW+1];
        rem_out = q_bit ? diff[VW:0] : shifted[VW:0];
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : signed 24/12 sequential divider, fixed 26-cycle latency
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_divider
    import arith_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          ready,
    output logic          done,
    output logic          div_by_zero,
    output logic          overflow
);

    div_state_t       state;
    div_state_t       next_state;

    logic [DW-1:0]    dvd_raw;
    logic [VW-1:0]    dvs_raw;
    logic [DW-1:0]    dvd_shift;
    logic [VW-1:0]    dvs_mag;
    logic [VW:0]      rem;
    logic             sign_q;
    logic             sign_r;
    logic [CNT_W-1:0] cnt;

    logic [VW:0]      rem_next;
    logic             q_bit;

    logic             fix_zero;
    logic             fix_ovf;
    logic [VW-1:0]    q_lo;
    logic [VW-1:0]    r_lo;

    div_step u_step (
        .rem_in  (rem),
        .dvd_bit (dvd_shift[DW-1]),
        .dvs     (dvs_mag),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = PREP;
            PREP:    next_state = ITER;
            ITER:    if (cnt == 5'd1) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // dvd_shift ends the iteration holding the unsigned quotient magnitude.
    always_comb begin
        fix_zero = (dvs_mag == '0);
        fix_ovf  = sign_q ? (dvd_shift > 24'd2048) : (dvd_shift > 24'd2047);
        q_lo     = dvd_shift[VW-1:0];
        r_lo     = rem[VW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_raw     <= '0;
            dvs_raw     <= '0;
            dvd_shift   <= '0;
            dvs_mag     <= '0;
            rem         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_raw <= dividend;
                        dvs_raw <= divisor;
                    end
                end
                PREP: begin
                    dvd_shift <= abs_dw(dvd_raw);
                    dvs_mag   <= abs_vw(dvs_raw);
                    sign_q    <= dvd_raw[DW-1] ^ dvs_raw[VW-1];
                    sign_r    <= dvd_raw[DW-1];
                    rem       <= '0;
                    cnt       <= ITER_COUNT;
                end
                ITER: begin
                    rem       <= rem_next;
                    dvd_shift <= {dvd_shift[DW-2:0], q_bit};
                    cnt       <= cnt - 5'd1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (fix_zero) begin
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                        quotient    <= sign_r ? Q_MIN : Q_MAX;
                        remainder   <= dvd_raw[VW-1:0];
                    end else if (fix_ovf) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                        quotient    <= sign_q ? Q_MIN : Q_MAX;
                        remainder   <= '0;
                    end else begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        quotient    <= sign_q ? (~q_lo + 1'b1) : q_lo;
                        remainder   <= sign_r ? (~r_lo + 1'b1) : r_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
